mem_port_arbiter: RTL

//  Shares one single-port unified memory between the IFU fetch port and the load/store port.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// One transaction in flight; load/store wins unless fetch has waited MAX_DSTREAK grants.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req_valid,
  input  logic [ADDR_W-1:0]     if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_rsp_valid,
  output logic [DATA_W-1:0]     if_rsp_data,
  input  logic                  ls_req_valid,
  input  logic                  ls_req_we,
  input  logic [ADDR_W-1:0]     ls_req_addr,
  input  logic [DATA_W-1:0]     ls_req_wdata,
  input  logic [DATA_W/8-1:0]   ls_req_wstrb,
  output logic                  ls_req_ready,
  output logic                  ls_rsp_valid,
  output logic [DATA_W-1:0]     ls_rsp_rdata,
  output logic                  mem_req_valid,
  output logic                  mem_req_we,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_wstrb,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_W-1:0]     mem_rsp_rdata,
  output logic                  busy,
  output logic                  owner,
  output logic                  protocol_err
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [STREAK_W-1:0]   r_streak;
  logic                  r_owner;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_if_rsp_valid;
  logic [DATA_W-1:0]     r_if_rsp_data;
  logic                  r_ls_rsp_valid;
  logic [DATA_W-1:0]     r_ls_rsp_rdata;
  logic                  r_protocol_err;
  logic                  w_grant_if;
  logic                  w_grant_ls;
  logic                  w_rsp_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_grant_ls || w_grant_if) w_next_state = S_REQ;
      S_REQ:      if (mem_req_ready) w_next_state = S_WAIT_RSP;
      S_WAIT_RSP: if (mem_rsp_valid) w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Grants are gated by reset so neither ready can rise while the block is held in reset.
  always_comb begin
    w_grant_ls    = 1'b0;
    w_grant_if    = 1'b0;
    if (r_state == S_IDLE && reset) begin
      w_grant_ls = ls_req_valid && !(if_req_valid && (r_streak == STREAK_MAX));
      w_grant_if = if_req_valid && !w_grant_ls;
    end
    if_req_ready  = w_grant_if;
    ls_req_ready  = w_grant_ls;
    mem_req_valid = (r_state == S_REQ);
    busy          = (r_state != S_IDLE);
  end

  assign w_rsp_done = (r_state == S_WAIT_RSP) && mem_rsp_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (w_grant_ls) begin
      r_owner <= 1'b1;
      r_we    <= ls_req_we;
      r_addr  <= ls_req_addr;
      r_wdata <= ls_req_wdata;
      r_wstrb <= ls_req_we ? ls_req_wstrb : '0;
    end else if (w_grant_if) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= if_req_addr;
      r_wdata <= '0;
      r_wstrb <= '0;
    end
  end

  // The streak only moves while arbitrating; a fetch grant or an absent fetch clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_streak <= '0;
    end else if (r_state == S_IDLE) begin
      if (!if_req_valid || w_grant_if) begin
        r_streak <= '0;
      end else if (w_grant_ls && (r_streak != STREAK_MAX)) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_rsp_valid <= 1'b0;
      r_if_rsp_data  <= '0;
      r_ls_rsp_valid <= 1'b0;
      r_ls_rsp_rdata <= '0;
    end else begin
      r_if_rsp_valid <= w_rsp_done && !r_owner;
      r_ls_rsp_valid <= w_rsp_done && r_owner;
      if (w_rsp_done && !r_owner) begin
        r_if_rsp_data <= mem_rsp_rdata;
      end
      if (w_rsp_done && r_owner) begin
        r_ls_rsp_rdata <= r_we ? '0 : mem_rsp_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_protocol_err <= 1'b0;
    end else if (mem_rsp_valid && (r_state != S_WAIT_RSP)) begin
      r_protocol_err <= 1'b1;
    end
  end

  assign if_rsp_valid  = r_if_rsp_valid;
  assign if_rsp_data   = r_if_rsp_data;
  assign ls_rsp_valid  = r_ls_rsp_valid;
  assign ls_rsp_rdata  = r_ls_rsp_rdata;
  assign mem_req_we    = r_we;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wstrb = r_wstrb;
  assign owner         = r_owner;
  assign protocol_err  = r_protocol_err;

endmodule
